// File: rtl/arya_pkg.sv
// Shared constants and types for the data-memory arbitration slice.
package arya_pkg;

    localparam int unsigned DATAPATH_WIDTH = 64;
    localparam int unsigned MEM_ADDR_WIDTH = 10;
    localparam int unsigned DATA_MEM_START = 512;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Core-side request bus and memory-side port of the data-memory arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned DATAPATH_WIDTH = arya_pkg::DATAPATH_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = arya_pkg::MEM_ADDR_WIDTH
);

    logic [NUM_CORES-1:0]                req;
    logic [NUM_CORES-1:0]                req_we;
    logic [NUM_CORES*MEM_ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CORES*DATAPATH_WIDTH-1:0] req_wdata;
    logic [NUM_CORES-1:0]                ack;
    logic [NUM_CORES-1:0]                stall;
    logic [DATAPATH_WIDTH-1:0]           rdata;

    logic                                mem_en;
    logic                                mem_we;
    logic [MEM_ADDR_WIDTH-1:0]           mem_addr;
    logic [DATAPATH_WIDTH-1:0]           mem_wdata;
    logic [DATAPATH_WIDTH-1:0]           mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output ack, stall, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  ack, stall, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
    parameter int unsigned NUM_CORES = 4,
    localparam int unsigned IDX_W    = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     winner
);

    always_comb begin
        logic [IDX_W:0] sum;
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            // ptr < NUM_CORES, so a single subtraction wraps the search index
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_CORES))
                sum = sum - (IDX_W+1)'(NUM_CORES);
            if (!valid && req[sum[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port among NUM_CORES cores.
// Each access is GRANT (drive memory) followed by RESP (ack + read data).
module dmem_port_arbiter #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned DATAPATH_WIDTH = arya_pkg::DATAPATH_WIDTH,
    parameter int unsigned MEM_ADDR_WIDTH = arya_pkg::MEM_ADDR_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);

    import arya_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_CORES);

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic                      mem_en_q, mem_en_d;
    logic                      mem_we_q, mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATAPATH_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [NUM_CORES-1:0]      owner_oh;
    logic [NUM_CORES-1:0]      pick_mask;
    logic [NUM_CORES-1:0]      ack;
    logic                      pick_valid;
    logic [IDX_W-1:0]          pick_idx;

    always_comb begin
        owner_oh           = '0;
        owner_oh[owner_q]  = 1'b1;
    end

    // In RESP the owner's req is still high but already being served.
    assign pick_mask = (state_q == ARB_RESP) ? (bus.req & ~owner_oh) : bus.req;

    rr_priority_pick #(
        .NUM_CORES (NUM_CORES)
    ) u_pick (
        .req    (pick_mask),
        .ptr    (rr_ptr_q),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ARB_IDLE, ARB_RESP: begin
                if (pick_valid) begin
                    state_d     = ARB_GRANT;
                    owner_d     = pick_idx;
                    rr_ptr_d    = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.req_we[pick_idx];
                    mem_addr_d  = bus.req_addr[pick_idx*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
                    mem_wdata_d = bus.req_wdata[pick_idx*DATAPATH_WIDTH +: DATAPATH_WIDTH];
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: state_d = ARB_RESP;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ack           = (state_q == ARB_RESP) ? owner_oh : '0;
    assign bus.ack       = ack;
    assign bus.stall     = bus.req & ~ack;
    assign bus.rdata     = (state_q == ARB_RESP) ? bus.mem_rdata : '0;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, ack scoreboard, corner sequences.
module tb_dmem_port_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.NUM_CORES(NC), .DATAPATH_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) bus ();

    dmem_port_arbiter #(.NUM_CORES(NC), .DATAPATH_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int            core;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        int            core;
        logic          chk;
        logic [DW-1:0] rdata;
    } sb_t;

    int            n_vec = 0;
    int            n_err = 0;
    sb_t           sb_q[$];
    logic [DW-1:0] mem [int];

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 600) return 64'h0000_0000_DEAD_BEEF;
        return 64'hA5A5_0000_0000_0000 | DW'(a);
    endfunction

    // Synchronous 1-cycle-read memory, read-before-write.
    always @(posedge clk) begin
        int a;
        if (bus.mem_en) begin
            a = int'(bus.mem_addr);
            bus.mem_rdata <= mem.exists(a) ? mem[a] : init_val(a);
            if (bus.mem_we) mem[a] = bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input int core, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        bus.req[core]                 = 1'b1;
        bus.req_we[core]              = we;
        bus.req_addr[core*AW +: AW]   = addr;
        bus.req_wdata[core*DW +: DW]  = wdata;
    endtask

    task automatic push_exp(input int core, input logic chk, input logic [DW-1:0] rdata);
        sb_t e;
        e.core  = core;
        e.chk   = chk;
        e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.req = '0;
        reset   = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
    endtask

    // Scoreboard: every ack pops the next expected completion.
    always @(negedge clk) begin
        sb_t e;
        if (!reset) begin
            check("stall_eq", DW'(bus.stall), DW'(bus.req & ~bus.ack));
            if (bus.ack != '0) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got ack %b, expected no ack", bus.ack);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_ack", DW'(bus.ack), DW'(1) << e.core);
                    if (e.chk) check("sb_rdata", bus.rdata, e.rdata);
                end
            end else begin
                check("rdata_idle", bus.rdata, '0);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        drive_req(v.core, v.we, v.addr, v.wdata);
        push_exp(v.core, !v.we, v.exp_rdata);
        @(negedge clk);
        check("n_mem_en", DW'(bus.mem_en), '0);
        check("n_stall", DW'(bus.stall[v.core]), DW'(1'b1));
        @(negedge clk);
        check("g_mem_en", DW'(bus.mem_en), DW'(1'b1));
        check("g_mem_we", DW'(bus.mem_we), DW'(v.we));
        check("g_mem_addr", DW'(bus.mem_addr), DW'(v.addr));
        if (v.we) check("g_mem_wdata", bus.mem_wdata, v.wdata);
        check("g_ack", DW'(bus.ack), '0);
        check("g_stall", DW'(bus.stall[v.core]), DW'(1'b1));
        @(negedge clk);
        check("r_ack", DW'(bus.ack), DW'(1) << v.core);
        check("r_mem_en", DW'(bus.mem_en), '0);
        check("r_mem_we", DW'(bus.mem_we), '0);
        @(posedge clk); #1;
        bus.req[v.core] = 1'b0;
        @(negedge clk);
        check("p_ack", DW'(bus.ack), '0);
        check("p_mem_en", DW'(bus.mem_en), '0);
    endtask

    initial begin
        vec_t       vecs[8];
        logic [3:0] done;
        logic [3:0] a;
        int         fc[3];
        int         seen;

        vecs[0] = '{2, 1'b0, 10'd600,  64'd0,                 64'h0000_0000_DEAD_BEEF};
        vecs[1] = '{0, 1'b1, 10'd520,  64'h1234,              64'd0};
        vecs[2] = '{0, 1'b0, 10'd520,  64'd0,                 64'h1234};
        vecs[3] = '{1, 1'b1, 10'd700,  64'hCAFE_F00D_0123_4567, 64'd0};
        vecs[4] = '{3, 1'b0, 10'd700,  64'd0,                 64'hCAFE_F00D_0123_4567};
        vecs[5] = '{1, 1'b0, 10'd1023, 64'd0,                 64'hA5A5_0000_0000_03FF};
        vecs[6] = '{3, 1'b1, 10'd0,    64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        vecs[7] = '{2, 1'b0, 10'd0,    64'd0,                 64'hFFFF_FFFF_FFFF_FFFF};
        fc      = '{1, 3, 1};

        bus.req       = 4'b1010;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_mem_en",    DW'(bus.mem_en),    '0);
        check("rst_mem_we",    DW'(bus.mem_we),    '0);
        check("rst_mem_addr",  DW'(bus.mem_addr),  '0);
        check("rst_mem_wdata", bus.mem_wdata,      '0);
        check("rst_ack",       DW'(bus.ack),       '0);
        check("rst_rdata",     bus.rdata,          '0);
        check("rst_stall",     DW'(bus.stall),     DW'(4'b1010));
        bus.req = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Full contention from reset: acks 0,1,2,3 two cycles apart
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive_req(i, 1'b0, AW'(10 + i), '0);
            push_exp(i, 1'b1, init_val(10 + i));
        end
        done = '0;
        for (int c = 0; c < 24 && done != 4'hF; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (bus.ack[k]) check($sformatf("cont_cycle_core%0d", k), DW'(c), DW'(2 + 2*k));
            done = done | bus.ack;
            @(posedge clk); #1;
            bus.req = bus.req & ~done;
        end
        if (done != 4'hF) begin
            n_vec++;
            n_err++;
            $display("FAIL cont_timeout: got acked %b, expected 1111", done);
        end

        // Core 1 re-requests right after its ack while core 3 waits
        do_reset();
        @(posedge clk); #1;
        drive_req(1, 1'b0, 10'd20, '0);
        drive_req(3, 1'b0, 10'd30, '0);
        push_exp(1, 1'b1, init_val(20));
        push_exp(3, 1'b1, init_val(30));
        push_exp(1, 1'b1, init_val(21));
        seen = 0;
        for (int c = 0; c < 24 && seen < 3; c++) begin
            @(negedge clk);
            a = bus.ack;
            if (a != '0) begin
                check($sformatf("fair_order%0d", seen), DW'(a), DW'(1) << fc[seen]);
                check($sformatf("fair_cycle%0d", seen), DW'(c), DW'(2 + 2*seen));
                seen++;
            end
            @(posedge clk); #1;
            if (a[1] && seen == 1) bus.req_addr[1*AW +: AW] = 10'd21;
            if (a[3]) bus.req[3] = 1'b0;
            if (a[1] && seen == 3) bus.req[1] = 1'b0;
        end
        if (seen != 3) begin
            n_vec++;
            n_err++;
            $display("FAIL fair_timeout: got %0d acks, expected 3", seen);
        end

        // Async reset in the middle of a GRANT cycle
        do_reset();
        @(posedge clk); #1;
        drive_req(2, 1'b0, 10'd40, '0);
        push_exp(2, 1'b1, init_val(40));
        @(posedge clk); #1;
        check("ar_pre_mem_en", DW'(bus.mem_en), DW'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        check("ar_mem_en",   DW'(bus.mem_en),   '0);
        check("ar_mem_addr", DW'(bus.mem_addr), '0);
        check("ar_ack",      DW'(bus.ack),      '0);
        check("ar_stall",    DW'(bus.stall),    DW'(4'b0100));
        @(posedge clk); #1;
        check("ar_hold_mem_en", DW'(bus.mem_en), '0);
        reset = 1'b0;
        drive_req(3, 1'b0, 10'd50, '0);
        push_exp(3, 1'b1, init_val(50));
        @(negedge clk);
        check("ar_idle_mem_en", DW'(bus.mem_en), '0);
        @(negedge clk);
        check("ar_regrant_en",   DW'(bus.mem_en),   DW'(1'b1));
        check("ar_regrant_addr", DW'(bus.mem_addr), DW'(10'd40));
        @(negedge clk);
        check("ar_ack2", DW'(bus.ack), DW'(4'b0100));
        @(posedge clk); #1;
        bus.req[2] = 1'b0;
        @(negedge clk);
        check("ar_next_addr", DW'(bus.mem_addr), DW'(10'd50));
        @(negedge clk);
        check("ar_ack3", DW'(bus.ack), DW'(4'b1000));
        @(posedge clk); #1;
        bus.req[3] = 1'b0;

        @(posedge clk); #1;
        check("sb_drain", DW'(sb_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1);
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbitrates the single shared data-memory port between the execute/memory pipeline stages of `NUM_CORES` cores using round-robin scheduling. It sequences each access through a 2-phase state machine: drive the memory, then return the response. While a core's request is pending and not yet acknowledged, the block drives that core's `stall` output, which gates the core's pipeline-register enables (`en = ~stall`). It sits between the per-core execute/memory pipeline registers and the data memory, which has a synchronous, 1-cycle-read interface.

## Interface
- `NUM_CORES`, 4: number of requesters, 2..8.
- `DATAPATH_WIDTH`, 64: data word width.
- `MEM_ADDR_WIDTH`, 10: memory address width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req` in NUM_CORES: per-core access request; held stable until its `ack`.
- `req_we` in NUM_CORES: 1 = write, 0 = read.
- `req_addr` in NUM_CORES*MEM_ADDR_WIDTH: flattened addresses; core i occupies slice [i*W +: W].
- `req_wdata` in NUM_CORES*DATAPATH_WIDTH: flattened write data, sliced the same way.
- `ack` out NUM_CORES: one-hot, 1-cycle completion pulse.
- `stall` out NUM_CORES: `req[i] & ~ack[i]`.
- `rdata` out DATAPATH_WIDTH: read data, valid with `ack`; 0 otherwise.
- `mem_en`, `mem_we` out 1: memory port strobes.
- `mem_addr` out MEM_ADDR_WIDTH: memory address.
- `mem_wdata` out DATAPATH_WIDTH: memory write data.
- `mem_rdata` in DATAPATH_WIDTH: memory read data, valid one cycle after `mem_en`.

## Operation
- State machine: IDLE, GRANT, RESP. Reset state is IDLE.
  - IDLE: if any `req` is high, pick a winner, load `owner`, register `mem_*` from the winner's slice with `mem_en=1`, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: memory samples the `mem_*` outputs at the end of the cycle. Clear `mem_en` and `mem_we`, then go to RESP.
  - RESP: `ack[owner]=1` and `rdata=mem_rdata`; for writes, `rdata` still passes `mem_rdata` and is ignored by the core. Arbitrate among `req & ~onehot(owner)`, because the owner's request is stale this cycle. If there is a winner, load it and go to GRANT. Otherwise go to IDLE.
- Round-robin: `rr_ptr` names the highest-priority core. Search order is `rr_ptr`, `rr_ptr+1`, … mod NUM_CORES. On every grant, `rr_ptr <= winner+1 mod NUM_CORES`.
- `ack` and `stall` are combinational from state, `owner` and `req`. All `mem_*` outputs are registered.
- Addresses pass through unmodified. Decoding the data-memory base (512) is the core's responsibility.
- Reset values: state=IDLE, `owner`=0, `rr_ptr`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. These give `ack`=0, `rdata`=0, and `stall=req`.

## Timing
- Latency: `req` rising in cycle n while IDLE → `mem_en` in n+1 → `ack` and `rdata` in n+2.
- Throughput: one access per 2 cycles under continuous contention. A competing core's GRANT cycle immediately follows the previous RESP.
- A core that receives `ack` in cycle k may present a new request from cycle k+1. It is then eligible only in the next arbitration, and the round-robin pointer already favours others.
- `req` deasserted before `ack` is a protocol violation. The in-flight access completes regardless.
- Simultaneous requests are resolved by `rr_ptr` only; there are no fixed priorities.
- Assertion of `reset` mid-GRANT: `mem_en` drops asynchronously and the access is abandoned. A write may or may not have landed; cores re-issue after reset.
- Assertion of `reset` mid-RESP: `ack` is withdrawn in the same cycle and the core does not advance.
- Starvation bound: any held request is acked within 2*NUM_CORES+2 cycles.

## Structure
- Shared package `arya_pkg`: `DATAPATH_WIDTH`, `MEM_ADDR_WIDTH`, `DATA_MEM_START`, and the state encoding constants `ARB_IDLE=2'd0`, `ARB_GRANT=2'd1`, `ARB_RESP=2'd2`.
- One sub-module, `rr_priority_pick`: purely combinational. Inputs are the request vector and the pointer; outputs are a `valid` flag and the binary winner index. It is instantiated once and its mask input is driven per state.

## Test plan
- Single read: core 2 `req` with addr 600 and the memory model returning 0xDEAD_BEEF at 600 → `mem_en` at n+1 with `mem_addr`=600, `ack`=4'b0100 and `rdata`=0xDEAD_BEEF at n+2; `stall[2]` high for cycles n and n+1.
- Write then read: core 0 writes 0x1234 to 520, then reads 520 → `mem_we`=1 only during the write's GRANT cycle; the read returns 0x1234.
- Full contention: all 4 cores request at once from reset → acks occur in order 0,1,2,3 at cycles n+2, n+4, n+6, n+8; each losing core's `stall` stays high until its own ack.
- Re-request fairness: core 1 re-requests immediately after its ack while core 3 is pending → core 3 is acked before core 1's second access.
- Async reset: assert `reset` mid-GRANT, between clock edges → `mem_en`, `ack` and state clear without waiting for a clock edge; after release, with `req` still high, the access restarts with `rr_ptr`=0.
